// File: rtl/wb_gpio_slave.sv
// Wishbone B4 classic slave for LEDs, switches and buttons with a sticky button-edge interrupt.
// One-cycle registered ack, at most one access per two clocks; there is no wait-state backpressure.
module wb_gpio_slave #(
    parameter int LED_WIDTH = 4,
    parameter int SW_WIDTH  = 4,
    parameter int BTN_WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic [LED_WIDTH-1:0] led_o,
    input  logic [SW_WIDTH-1:0]  sw_i,
    input  logic [BTN_WIDTH-1:0] btn_i,
    output logic                 irq_o
);

    localparam logic [1:0] REG_LED    = 2'd0;
    localparam logic [1:0] REG_IN     = 2'd1;
    localparam logic [1:0] REG_EDGE   = 2'd2;
    localparam logic [1:0] REG_IRQ_EN = 2'd3;

    logic [SW_WIDTH-1:0]  sw_meta;
    logic [SW_WIDTH-1:0]  sw_sync;
    logic [BTN_WIDTH-1:0] btn_meta;
    logic [BTN_WIDTH-1:0] btn_sync;
    logic [BTN_WIDTH-1:0] btn_prev;
    logic [BTN_WIDTH-1:0] edge_q;
    logic [BTN_WIDTH-1:0] edge_nxt;
    logic [BTN_WIDTH-1:0] irq_en;
    logic [31:0]          rd_dat;
    logic [1:0]           reg_sel;
    logic                 acc;
    logic                 wr;
    logic                 unused_bits;

    assign reg_sel = wb_adr_i[3:2];
    // Suppressing acc while ack is high makes each access exactly one ack wide.
    assign acc     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr      = acc & wb_we_i & wb_sel_i[0];

    assign unused_bits = ^{wb_adr_i, wb_sel_i, wb_dat_i};

    always_comb begin
        rd_dat = '0;
        case (reg_sel)
            REG_LED: rd_dat[LED_WIDTH-1:0] = led_o;
            REG_IN: begin
                rd_dat[SW_WIDTH-1:0]                  = sw_sync;
                rd_dat[SW_WIDTH+BTN_WIDTH-1:SW_WIDTH] = btn_sync;
            end
            REG_EDGE: rd_dat[BTN_WIDTH-1:0] = edge_q;
            default:  rd_dat[BTN_WIDTH-1:0] = irq_en;
        endcase
    end

    // Clear is applied before set so a coincident new edge is never lost.
    always_comb begin
        edge_nxt = edge_q;
        if (wr && reg_sel == REG_EDGE)
            edge_nxt = edge_nxt & ~wb_dat_i[BTN_WIDTH-1:0];
        edge_nxt = edge_nxt | (btn_sync & ~btn_prev);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
            btn_prev <= '0;
            edge_q   <= '0;
            irq_en   <= '0;
            led_o    <= '0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            irq_o    <= 1'b0;
        end else begin
            sw_meta  <= sw_i;
            sw_sync  <= sw_meta;
            btn_meta <= btn_i;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
            edge_q   <= edge_nxt;
            irq_o    <= |(edge_q & irq_en);
            wb_ack_o <= acc;
            if (acc)
                wb_dat_o <= rd_dat;
            if (wr && reg_sel == REG_LED)
                led_o <= wb_dat_i[LED_WIDTH-1:0];
            if (wr && reg_sel == REG_IRQ_EN)
                irq_en <= wb_dat_i[BTN_WIDTH-1:0];
        end
    end

endmodule

// File: doc/wb_gpio_slave.md
# wb_gpio_slave

Wishbone B4 classic-cycle responder that gives the picorv32 SoC access to the Arty board's LEDs, switches and buttons. It sits on the SoC data bus as a peripheral slave and answers the core's bus master. Switch and button inputs are synchronised into the `clock` domain. Rising button edges are latched into a write-1-to-clear register that drives a level interrupt.

## Interface
Parameters:
- LED_WIDTH, 4, number of driven LEDs (1..8)
- SW_WIDTH, 4, number of switch inputs (1..8)
- BTN_WIDTH, 4, number of button inputs (1..8)

Ports:
- clock  in  1  system clock (10 MHz on Arty)
- reset  in  1  asynchronous, active-high reset
- wb_adr_i  in  32  byte address; only bits [3:2] decoded, all others ignored (aliasing)
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte selects; only wb_sel_i[0] used
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  acknowledge
- led_o  out  LED_WIDTH  LED drive
- sw_i  in  SW_WIDTH  asynchronous switch inputs
- btn_i  in  BTN_WIDTH  asynchronous button inputs
- irq_o  out  1  level interrupt

## Operation
- Register map by wb_adr_i[3:2]. Unused upper bits read 0.
  - 0 LED: RW, bits [LED_WIDTH-1:0]
  - 1 IN: RO, {btn_sync, sw_sync}; sw in [SW_WIDTH-1:0], btn in [SW_WIDTH+BTN_WIDTH-1:SW_WIDTH]
  - 2 EDGE: RW1C, bits [BTN_WIDTH-1:0], sticky rising-edge flags per button
  - 3 IRQ_EN: RW, bits [BTN_WIDTH-1:0]
- Synchroniser: sw_i and btn_i each pass through 2 flops, giving sw_sync and btn_sync. A third flop, btn_prev, holds the previous btn_sync.
- Edge capture: edge[i] is set when btn_sync[i] & ~btn_prev[i].
- A write to EDGE with wb_sel_i[0]=1 clears every edge bit whose wb_dat_i bit is 1.
- If a set and a clear of the same bit land in the same cycle, the set wins.
- Writes take effect only when wb_sel_i[0]=1. Writes to IN are ignored but still acked.
- irq_o = |(edge & irq_en), registered (one flop after edge/irq_en update).
- Handshake: wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - Every access is acked. There is no error/retry.
  - The register write and the wb_dat_o capture happen on the same edge that raises wb_ack_o.
  - wb_dat_o holds its value until the next access.
- Dropping wb_cyc_i or wb_stb_i before the ack: no write occurs if the drop precedes the write edge; otherwise the access completes normally.
- Reset state (asynchronous, all flops):
  - led_o=0, wb_ack_o=0, wb_dat_o=0, irq_o=0
  - edge=0, irq_en=0
  - all synchroniser flops and btn_prev = 0
- A button held through reset release therefore sets its edge bit 3 clocks after release.
- Reset asserted mid-transfer aborts it: ack does not appear, and any pending write is lost.

## Timing
- Access latency: wb_ack_o is high in the cycle after the first cycle with cyc&stb, and stays high for exactly 1 cycle.
- With cyc&stb held, the next ack comes 2 cycles later (max 1 access per 2 clocks).
- LED write: led_o changes on the same edge as wb_ack_o rises.
- Input path: an sw_i/btn_i change is visible in IN 2–3 clocks later. The edge bit sets 1 clock after btn_sync rises. irq_o rises 1 clock after the edge bit.
- Worst case btn_i rise to irq_o: 5 clocks.

## Test plan
- After reset: read all 4 registers; wb_dat_o returns 0x0 each time; led_o=0, irq_o=0; each ack is exactly 1 cycle wide.
- Write LED 0xA with sel=0x1: led_o=4'b1010 on the ack edge, and reading LED gives 0x0000000A. Write 0xF with sel=0x0: led_o stays 4'b1010.
- Drive sw_i=4'h5, btn_i=4'h0 and wait 3 clocks: reading IN gives 0x05. Write IN with 0xFF: acked, IN still 0x05.
- Set IRQ_EN=0x2, then pulse btn_i[1] high for 10 clocks:
  - EDGE reads 0x2 and irq_o rises ≤5 clocks after the btn_i rise.
  - Write EDGE 0x2: EDGE=0 and irq_o falls 1 clock later.
- Arrange for btn_sync[0] to rise in the same cycle as the EDGE write of 0x1: EDGE[0] reads 1 afterwards (set wins).
- Assert reset for 1 cycle while an LED write is pending (cyc&stb high, before ack): no ack, led_o=0; after release the retried write acks normally.
